// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared constants and types for the instruction-RAM loader:
//            frame header byte, bytes per instruction word and the loader
//            state encoding.
// Ports    : (package, none)
// Revision : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

    localparam logic [7:0] HDR_BYTE       = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : word_assembler
// Purpose  : Collects bytes most-significant first into a 32-bit word and
//            flags the cycle in which the final byte of a word is accepted.
// Ports    : clk, reset      clock, asynchronous active-high reset
//            clear_i         restart at byte 0 of a new word
//            byte_valid_i    byte_i is consumed this cycle
//            byte_i          incoming byte
//            word_done_o     this cycle's byte completes a word
//            word_o          assembled word, valid while word_done_o is high
// Revision : 1.0  initial release
// ============================================================================
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_done_o,
    output logic [31:0] word_o
);

    localparam int CNT_W   = $clog2(BYTES_PER_WORD);
    localparam int SHIFT_W = (BYTES_PER_WORD - 1) * 8;

    logic [CNT_W-1:0]   cnt_q;
    logic [SHIFT_W-1:0] shift_q;

    // The final byte is combined directly with the stored bytes, so the
    // word is available in the same cycle the last byte arrives.
    assign word_done_o = byte_valid_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign word_o      = {shift_q, byte_i};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (clear_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid_i) begin
            shift_q <= {shift_q[SHIFT_W-9:0], byte_i};
            cnt_q   <= word_done_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Receives a framed byte stream (A5, count, big-endian words,
//            XOR checksum), writes the words into instruction RAM and holds
//            the CPU in reset until a verified image is present.
// Ports    : clk, reset      clock, asynchronous active-high reset
//            rx_valid/ready  byte handshake, rx_data the byte
//            imem_we/addr/wdata  registered instruction RAM write port
//            cpu_hold        core reset, low only with a verified image
//            done / error    image verified / last frame failed
// Revision : 1.0  initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [7:0]          chk_q, chk_d;
    logic [TO_W-1:0]     idle_q, idle_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                xfer;
    logic                cnt_ok;
    logic                timed;
    logic                timeout_hit;
    logic                asm_clear;
    logic                asm_valid;
    logic                asm_done;
    logic [31:0]         asm_word;

    // The loader never back-pressures; only reset blocks transfers.
    assign rx_ready = ~reset;
    assign xfer     = rx_valid & rx_ready;

    // Nine-bit compare so that DEPTH = 256 is representable.
    assign cnt_ok = (rx_data != 8'd0) && ({1'b0, rx_data} <= 9'(DEPTH));

    assign timed       = (state_q == ST_COUNT) || (state_q == ST_DATA) ||
                         (state_q == ST_CHECK);
    assign timeout_hit = timed && !xfer && (idle_q == TO_W'(TIMEOUT - 1));

    assign asm_clear = (state_q == ST_COUNT) && xfer;
    assign asm_valid = (state_q == ST_DATA) && xfer;

    word_assembler u_word_assembler (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_valid),
        .byte_i       (rx_data),
        .word_done_o  (asm_done),
        .word_o       (asm_word)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        chk_d   = chk_q;
        idle_d  = '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (timed) begin
            idle_d = xfer ? '0 : idle_q + TO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (xfer && rx_data == HDR_BYTE) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (xfer) begin
                    if (cnt_ok) begin
                        // Store the index of the final word rather than N.
                        last_d  = ADDR_W'(rx_data - 8'd1);
                        idx_d   = '0;
                        chk_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    chk_d = chk_q ^ rx_data;
                    if (asm_done) begin
                        we_d    = 1'b1;
                        addr_d  = idx_q;
                        wdata_d = asm_word;
                        if (idx_q == last_q) begin
                            state_d = ST_CHECK;
                        end else begin
                            idx_d = idx_q + ADDR_W'(1);
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (xfer) begin
                    state_d = (rx_data == chk_q) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (xfer && rx_data == HDR_BYTE) begin
                    state_d = ST_COUNT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timeout only fires in idle cycles, so it never races a transfer.
        if (timeout_hit) begin
            state_d = ST_ERR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            chk_q   <= '0;
            idle_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            chk_q   <= chk_d;
            idle_q  <= idle_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader. Frames are generated from
//            word lists; expected RAM writes and status are queued when each
//            byte is sent and compared by an independent monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 1024;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam logic [7:0] HDR = 8'hA5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Posedge count; read at a negedge it names the edge just passed.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct { int cyc; int addr; logic [31:0] data; } wr_t;
    typedef struct { int cyc; logic hold; logic dn; logic err; } st_t;

    wr_t wq[$];
    st_t sq[$];

    logic [31:0] words [DEPTH];
    int          gap_max = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    wr_t m_w;
    st_t m_s;
    always @(negedge clk) begin
        if (imem_we !== 1'b0) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr %h data %h at cycle %0d",
                         imem_addr, imem_wdata, cyc);
            end else begin
                m_w = wq.pop_front();
                chk("write_cycle", 32'(cyc), 32'(m_w.cyc));
                chk("write_addr", 32'(imem_addr), 32'(m_w.addr));
                chk("write_data", imem_wdata, m_w.data);
            end
        end
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            m_s = sq.pop_front();
            if (m_s.cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL status_missed: expected at cycle %0d now %0d", m_s.cyc, cyc);
            end else begin
                chk("cpu_hold", 32'(cpu_hold), 32'(m_s.hold));
                chk("done", 32'(done), 32'(m_s.dn));
                chk("error", 32'(error), 32'(m_s.err));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send_byte(input logic [7:0] b, output int acc);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        acc      = cyc + 1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
    endtask

    task automatic rand_gap();
        if (gap_max > 0) idle_cycles($urandom_range(0, gap_max));
    endtask

    // Sends A5, count, then (for a legal count) the words of `words` and
    // the checksum, queueing the outcome the frame rules dictate.
    task automatic send_frame(input int cnt, input bit bad_chk);
        int         acc;
        logic [7:0] x;
        logic [7:0] b;
        send_byte(HDR, acc);
        sq.push_back('{acc, 1'b1, 1'b0, 1'b0});
        rand_gap();
        send_byte(8'(cnt), acc);
        if (cnt < 1 || cnt > DEPTH) begin
            sq.push_back('{acc, 1'b1, 1'b0, 1'b1});
            idle_cycles(1);
            return;
        end
        x = 8'h00;
        for (int w = 0; w < cnt; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = words[w][31 - 8*k -: 8];
                rand_gap();
                send_byte(b, acc);
                x = x ^ b;
                if (k == 3) wq.push_back('{acc, w, words[w]});
            end
        end
        rand_gap();
        send_byte(bad_chk ? (x ^ 8'h01) : x, acc);
        if (bad_chk) sq.push_back('{acc, 1'b1, 1'b0, 1'b1});
        else         sq.push_back('{acc, 1'b0, 1'b1, 1'b0});
        idle_cycles(1);
    endtask

    task automatic fill_words(input int n);
        for (int i = 0; i < n; i++) words[i] = $urandom;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'(0));
        chk({tag, "_imem_we"}, 32'(imem_we), 32'(0));
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'(0));
        chk({tag, "_imem_wdata"}, imem_wdata, 32'(0));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(1));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_error"}, 32'(error), 32'(0));
    endtask

    // ---------------- sequence ----------------
    initial begin
        int acc;
        logic [7:0] nb;

        // Reset with a header byte offered; nothing may transfer.
        #1;
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = HDR;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        idle_cycles(2);

        // Noise in IDLE is discarded.
        send_byte(8'h00, acc);
        send_byte(8'hFF, acc);
        send_byte(8'h5A, acc);
        idle_cycles(1);

        // Reference two-word frame, good then bad checksum then good.
        words[0] = 32'h20080005;
        words[1] = 32'h2009000A;
        send_frame(2, 1'b0);
        idle_cycles(3);
        send_frame(2, 1'b1);
        idle_cycles(3);
        send_frame(2, 1'b0);
        idle_cycles(3);

        // Count bounds.
        send_frame(0, 1'b0);
        idle_cycles(2);
        send_frame(DEPTH + 1, 1'b0);
        idle_cycles(2);
        fill_words(DEPTH);
        send_frame(DEPTH, 1'b0);
        idle_cycles(2);

        // Reload header from DONE, then stall mid-word until timeout.
        send_byte(HDR, acc);
        sq.push_back('{acc, 1'b1, 1'b0, 1'b0});
        send_byte(8'h01, acc);
        send_byte(8'h20, acc);
        send_byte(8'h08, acc);
        sq.push_back('{acc + TIMEOUT - 1, 1'b1, 1'b0, 1'b0});
        sq.push_back('{acc + TIMEOUT,     1'b1, 1'b0, 1'b1});
        idle_cycles(TIMEOUT + 3);

        fill_words(1);
        send_frame(1, 1'b0);
        idle_cycles(2);

        // Reset after two data bytes: no strobe, reset values at once.
        send_byte(HDR, acc);
        sq.push_back('{acc, 1'b1, 1'b0, 1'b0});
        send_byte(8'h02, acc);
        send_byte(8'h11, acc);
        send_byte(8'h22, acc);
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = HDR;
        #1;
        check_reset_values("midreset");
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        idle_cycles(2);
        fill_words(3);
        send_frame(3, 1'b0);
        idle_cycles(2);

        // Randomised frames with gaps, noise, bad counts and bad checksums.
        for (int it = 0; it < 25; it++) begin
            gap_max = $urandom_range(0, 2);
            for (int j = 0; j < $urandom_range(0, 2); j++) begin
                nb = 8'($urandom);
                if (nb == HDR) nb = 8'h00;
                send_byte(nb, acc);
            end
            idle_cycles($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) begin
                send_frame(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH + 1, 255), 1'b0);
            end else begin
                int n;
                n = $urandom_range(1, DEPTH);
                fill_words(n);
                send_frame(n, $urandom_range(0, 3) == 0);
            end
        end
        gap_max = 0;

        idle_cycles(5);
        chk("write_queue_drained", 32'(wq.size()), 32'(0));
        chk("status_queue_drained", 32'(sq.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Serial program loader that writes instruction words into the processor's instruction RAM, the writing side of the instruction-fetch path. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It drives the instruction RAM write port and holds the MIPS core in reset until a complete, checksum-verified image has been written.

## Interface
- `ADDR_W`, default 4: instruction RAM word-address width; DEPTH = 2**ADDR_W words; legal range 1..8.
- `TIMEOUT`, default 1024: maximum idle cycles between bytes inside a frame; must be ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  byte present on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte this cycle; a byte transfers when `rx_valid & rx_ready`.
- `imem_we`  out  1  one-cycle write strobe to the instruction RAM.
- `imem_addr`  out  ADDR_W  word address for the write.
- `imem_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  drives the core's `reset`; high while no verified image is present.
- `done`  out  1  a verified image is loaded.
- `error`  out  1  the last frame failed.

## Operation
- Frame format:
  - HDR = 0xA5.
  - CNT = N words, with 1 ≤ N ≤ DEPTH.
  - 4·N data bytes, most significant byte first.
  - CHK = XOR of all 4·N data bytes.
- States: IDLE, COUNT, DATA, CHECK, DONE, ERR.
- IDLE:
  - Byte 0xA5 → COUNT.
  - Any other byte is discarded; stay in IDLE.
- COUNT:
  - Byte in 1..DEPTH → latch N, clear word index and checksum → DATA.
  - Otherwise → ERR.
- DATA:
  - Each byte shifts into a 32-bit assembly register: first byte lands in [31:24], fourth byte in [7:0].
  - Each byte XORs into the running checksum.
  - On the 4th byte of a word, the write is issued; the word index increments.
  - After word N-1 is written → CHECK.
- CHECK:
  - Byte equals the checksum → DONE.
  - Otherwise → ERR.
- DONE:
  - `cpu_hold` = 0 and `done` = 1.
  - Byte 0xA5 → `cpu_hold` = 1, `done` = 0 → COUNT (reload).
  - Other bytes are ignored.
- ERR:
  - `error` = 1, `cpu_hold` = 1.
  - Byte 0xA5 → clear `error` → COUNT.
  - Other bytes are discarded.
- Timeout:
  - In COUNT, DATA or CHECK, an idle counter counts cycles without a transfer.
  - It resets on every transfer.
  - On reaching TIMEOUT → ERR.
- RAM contents from a failed frame are not cleared; `cpu_hold` guarantees they are never executed.
- Words beyond N keep their prior contents.
- `rx_ready` = 1 in every state except during reset; the loader never back-pressures.

## Timing
- Reset values:
  - State IDLE.
  - `rx_ready` = 0 while `reset` is high, 1 otherwise.
  - `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `cpu_hold` = 1, `done` = 0, `error` = 0.
  - Idle counter 0.
- Byte throughput: one byte per cycle sustained.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered.
  - `imem_we` is high for exactly the one cycle after the 4th byte of a word is accepted.
  - Address and data are valid in that same cycle.
  - Back-to-back words at full rate produce strobes 4 cycles apart.
- `cpu_hold` falls, and `done` rises, in the cycle after the CHK byte is accepted. The last data write has completed at least one cycle earlier.
- `cpu_hold` rises in the cycle after an 0xA5 byte is accepted in DONE.
- `error` rises in the cycle after the bad byte is accepted, or after the timeout is reached.
- Timeout: with no transfer for TIMEOUT consecutive cycles, the loader enters ERR on the TIMEOUT-th idle cycle.
- Reset asserted mid-frame returns all state to reset values immediately.
  - No partial write is issued.
  - RAM contents are retained; the RAM itself is not reset.
- `rx_valid` held high with `rx_ready` low during reset transfers nothing.

## Structure
- Shared package holds:
  - `HDR_BYTE` = 8'hA5.
  - The loader state enum (IDLE, COUNT, DATA, CHECK, DONE, ERR).
  - The frame byte-width constant (4 bytes per word).
- One natural sub-module: `word_assembler`, a 4-byte shift register plus byte counter that emits a word-complete pulse with the assembled word.
- Timeout counter and checksum stay in the top FSM.

## Test plan
- Good 2-word frame: feed A5 02 20 08 00 05 20 09 00 0A 0E.
  - Required: writes 0x20080005 @0 and 0x2009000A @1, strobes 4 cycles apart.
  - Required: `cpu_hold` falls and `done` = 1 one cycle after 0x0E.
- Bad checksum: same frame ending in 0x0F.
  - Required: both writes still occur; `error` = 1, `cpu_hold` stays 1, `done` = 0.
  - Follow with the correct frame: `error` clears, then `done` = 1.
- Count bounds:
  - CNT = 0x00 → ERR.
  - CNT = 0x11 with ADDR_W = 4 → ERR, no writes.
  - CNT = 0x10 with 64 data bytes → writes to addresses 0..15, index 15 the last.
- Noise and timeout:
  - Bytes 00 FF 5A before A5 are ignored.
  - A5 01 20 08, then 1024 idle cycles → ERR, no `imem_we`.
- Reload and reset:
  - After DONE, send A5: `cpu_hold` = 1 the next cycle.
  - Assert `reset` after 2 data bytes: outputs at reset values, no strobe.
  - A subsequent full frame loads correctly from address 0.
